ll_fetch: RTL and testbench

LL_FETCH -- requirements
Module: ll_fetch

---
 rtl/dma_pkg.sv | 18 +
 rtl/ll_fetch.sv | 153 +++++++++++++++
 tb/tb_ll_fetch.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared DMA definitions: linked-list fetch FSM states and AXI encodings.
package dma_pkg;

  localparam int unsigned LL_WORDS_DEFAULT = 6;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_4B    = 3'd2;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAck  = 3'd1,
    StAr   = 3'd2,
    StR    = 3'd3,
    StErr  = 3'd4
  } ll_state_t;

endpackage

// File: rtl/ll_fetch.sv
// Linked-list descriptor fetcher: issues one AXI INCR read burst per request and
// forwards each returned word, one cycle later, with its index within the descriptor.
module ll_fetch
  import dma_pkg::*;
#(
  parameter int unsigned LL_WORDS = LL_WORDS_DEFAULT,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned LL_ARID  = 0
) (
  input  logic            clk,
  input  logic            rst,
  // descriptor request side
  input  logic            ll_req,
  input  logic [31:0]     ll_addr,
  output logic            ll_ack,
  output logic            ll_dvld,
  output logic [2:0]      ll_dcnt,
  output logic [31:0]     ll_rdata,
  // control
  input  logic            halt,
  input  logic            bf,
  input  logic            cf,
  // AXI read address channel
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [3:0]      arcache,
  output logic [ID_W-1:0] arid,
  // AXI read data channel
  input  logic            rvalid,
  output logic            rready,
  input  logic [31:0]     rdata_i,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic [ID_W-1:0] rid,
  // error reporting
  output logic            fetch_err,
  input  logic            clr_err
);

  ll_state_t   r_state;
  ll_state_t   w_state_nxt;
  logic [31:0] r_addr;
  logic [1:0]  r_cache;
  logic [2:0]  r_bcnt;
  logic        r_over;     // burst ran past the last descriptor word
  logic        r_ar_hold;  // arvalid already shown without handshake
  logic        r_dvld;
  logic [2:0]  r_dcnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic w_beat;
  logic w_last_idx;
  logic w_resp_ok;
  logic w_fwd;
  logic w_err_set;
  logic w_unused_rid;

  assign w_beat     = (r_state == StR) && rvalid;
  assign w_last_idx = (r_bcnt == 3'(LL_WORDS - 1));
  assign w_resp_ok  = (rresp == RESP_OKAY);
  assign w_fwd      = w_beat && w_resp_ok && !r_over;

  // Error sources: bad address, bad response, short burst, long burst.
  assign w_err_set = (r_state == StErr)
                   || (w_beat && !w_resp_ok)
                   || (w_beat && rlast && !w_last_idx && !r_over)
                   || (w_beat && !rlast && w_last_idx && !r_over);

  // The single read ID is fixed; returned IDs carry no information here.
  assign w_unused_rid = ^rid;

  assign ll_ack    = (r_state == StAck);
  assign ll_dvld   = r_dvld;
  assign ll_dcnt   = r_dcnt;
  assign ll_rdata  = r_rdata;
  assign fetch_err = r_err;

  // Once shown, arvalid must stay up until accepted even if halt rises.
  assign arvalid = (r_state == StAr) && (!halt || r_ar_hold);
  assign araddr  = r_addr;
  assign arlen   = 8'(LL_WORDS - 1);
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arcache = {2'b00, r_cache};
  assign arid    = ID_W'(LL_ARID);
  assign rready  = (r_state == StR);

  // Next-state decode of the fetch FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: if (ll_req) w_state_nxt = StAck;
      StAck:  w_state_nxt = (ll_addr[4:0] == 5'd0) ? StAr : StErr;
      StAr:   if (arvalid && arready) w_state_nxt = StR;
      StR:    if (w_beat && rlast) w_state_nxt = StIdle;
      StErr:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State, request latch, beat counter, data forwarding and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_addr    <= 32'd0;
      r_cache   <= 2'd0;
      r_bcnt    <= 3'd0;
      r_over    <= 1'b0;
      r_ar_hold <= 1'b0;
      r_dvld    <= 1'b0;
      r_dcnt    <= 3'd0;
      r_rdata   <= 32'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ar_hold <= arvalid && !arready;
      r_dvld    <= w_fwd;

      if (r_state == StAck) begin
        r_addr  <= ll_addr;
        r_cache <= {cf, bf};
      end

      if (w_beat) begin
        if (rlast) begin
          r_bcnt <= 3'd0;
          r_over <= 1'b0;
        end else if (w_last_idx) begin
          r_over <= 1'b1;  // hold the index; further beats are drained silently
        end else begin
          r_bcnt <= r_bcnt + 3'd1;
        end
      end

      if (w_fwd) begin
        r_dcnt  <= r_bcnt;
        r_rdata <= rdata_i;
      end

      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ll_fetch.sv
// Self-checking bench for ll_fetch with a queue-based model of forwarded words.
module tb_ll_fetch;
  import dma_pkg::*;

  localparam int unsigned NW  = 6;
  localparam int unsigned IDW = 4;
  localparam int unsigned AID = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            ll_req;
  logic [31:0]     ll_addr;
  logic            ll_ack;
  logic            ll_dvld;
  logic [2:0]      ll_dcnt;
  logic [31:0]     ll_rdata;
  logic            halt, bf, cf;
  logic            arvalid, arready;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [3:0]      arcache;
  logic [IDW-1:0]  arid;
  logic            rvalid, rready;
  logic [31:0]     rdata_i;
  logic [1:0]      rresp;
  logic            rlast;
  logic [IDW-1:0]  rid;
  logic            fetch_err, clr_err;

  ll_fetch #(.LL_WORDS(NW), .ID_W(IDW), .LL_ARID(AID)) dut (
    .clk(clk), .rst(rst),
    .ll_req(ll_req), .ll_addr(ll_addr), .ll_ack(ll_ack),
    .ll_dvld(ll_dvld), .ll_dcnt(ll_dcnt), .ll_rdata(ll_rdata),
    .halt(halt), .bf(bf), .cf(cf),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arcache(arcache), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata_i(rdata_i), .rresp(rresp),
    .rlast(rlast), .rid(rid),
    .fetch_err(fetch_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  dcnt;
    logic [31:0] data;
    int          cyc;
  } word_t;

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  word_t got_q[$];
  word_t exp_q[$];
  int    ack_cnt, arv_cnt, arv_in_r;

  logic [31:0] data_a[16];
  logic [1:0]  resp_a[16];
  logic [31:0] seen_araddr;
  logic [7:0]  seen_arlen;
  logic [2:0]  seen_arsize;
  logic [1:0]  seen_arburst;
  logic [3:0]  seen_arcache;
  logic [IDW-1:0] seen_arid;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (ll_dvld) got_q.push_back('{dcnt: ll_dcnt, data: ll_rdata, cyc: cyc});
    if (ll_ack) ack_cnt++;
    if (arvalid) arv_cnt++;
    if (arvalid && rready) arv_in_r++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    ack_cnt  = 0;
    arv_cnt  = 0;
    arv_in_r = 0;
  endtask

  task automatic fill_words(input int nb, input bit allow_err);
    for (int b = 0; b < 16; b++) begin
      data_a[b] = $urandom;
      resp_a[b] = RESP_OKAY;
      if (allow_err && b < nb && $urandom_range(0, 5) == 0) resp_a[b] = 2'($urandom_range(2, 3));
    end
  endtask

  // Request, wait for ack, then complete the AR handshake (bounded waits).
  task automatic do_req_ar(input logic [31:0] addr, input bit keep_req, input bit rand_ready);
    bit ok;
    bit first;
    ll_addr = addr;
    ll_req  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ll_ack) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL ack_wait: ll_ack=0 after 20 cycles, required 1");
      ll_req = 1'b0;
      return;
    end
    tick();
    if (!keep_req) ll_req = 1'b0;
    ok = 1'b0;
    first = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      arready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (arvalid && first) begin
        seen_araddr  = araddr;
        seen_arlen   = arlen;
        seen_arsize  = arsize;
        seen_arburst = arburst;
        seen_arcache = arcache;
        seen_arid    = arid;
        first = 1'b0;
      end
      ok = arvalid && arready;
      tick();
    end
    arready = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL ar_wait: no AR handshake in 60 cycles, required one");
    end
  endtask

  // Slave R channel; the model forwards every OKAY beat that lies inside the descriptor.
  task automatic drive_beats(input int nb, input bit rand_gaps, input bit set_last);
    for (int b = 0; b < nb; b++) begin
      if (rand_gaps) begin
        int g;
        g = int'($urandom_range(0, 2));
        repeat (g) tick();
      end
      rvalid  = 1'b1;
      rdata_i = data_a[b];
      rresp   = resp_a[b];
      rlast   = set_last && (b == nb - 1);
      rid     = IDW'(AID);
      if (resp_a[b] == RESP_OKAY && b < int'(NW))
        exp_q.push_back('{dcnt: 3'(b), data: data_a[b], cyc: cyc + 1});
      tick();
      rvalid = 1'b0;
      rlast  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    ll_req = 1'b1;
    ll_addr = 32'h1000_0040;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (ll_ack !== 1'b0)     begin n_err++; $display("FAIL rst_ack: got %b want 0", ll_ack); end
    n_cmp++; if (ll_dvld !== 1'b0)    begin n_err++; $display("FAIL rst_dvld: got %b want 0", ll_dvld); end
    n_cmp++; if (arvalid !== 1'b0)    begin n_err++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
    n_cmp++; if (rready !== 1'b0)     begin n_err++; $display("FAIL rst_rready: got %b want 0", rready); end
    n_cmp++; if (fetch_err !== 1'b0)  begin n_err++; $display("FAIL rst_err: got %b want 0", fetch_err); end
    n_cmp++; if (ll_dcnt !== 3'd0)    begin n_err++; $display("FAIL rst_dcnt: got %0d want 0", ll_dcnt); end
    n_cmp++; if (ll_rdata !== 32'd0)  begin n_err++; $display("FAIL rst_rdata: got %h want 0", ll_rdata); end
    n_cmp++; if (araddr !== 32'd0)    begin n_err++; $display("FAIL rst_araddr: got %h want 0", araddr); end
    tick();
    ll_req = 1'b0;
    rst    = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    clear_obs();
    fill_words(NW, 1'b0);
    bf = 1'($urandom_range(0, 1));
    cf = 1'($urandom_range(0, 1));
    do_req_ar(32'h1000_0040, 1'b0, 1'b1);
    drive_beats(NW, 1'b1, 1'b1);
    repeat (3) tick();
    n_cmp++; if (ack_cnt !== 1) begin n_err++; $display("FAIL basic_acks: got %0d want 1", ack_cnt); end
    n_cmp++; if (seen_araddr !== 32'h1000_0040) begin n_err++; $display("FAIL basic_araddr: got %h want 10000040", seen_araddr); end
    n_cmp++; if (seen_arlen !== 8'd5) begin n_err++; $display("FAIL basic_arlen: got %0d want 5", seen_arlen); end
    n_cmp++; if (seen_arsize !== 3'd2 || seen_arburst !== 2'b01)
      begin n_err++; $display("FAIL basic_size_burst: got %0d/%0d want 2/1", seen_arsize, seen_arburst); end
    n_cmp++; if (seen_arcache !== {2'b00, cf, bf})
      begin n_err++; $display("FAIL basic_arcache: got %b want %b", seen_arcache, {2'b00, cf, bf}); end
    n_cmp++; if (seen_arid !== IDW'(AID)) begin n_err++; $display("FAIL basic_arid: got %0d want %0d", seen_arid, AID); end
    n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b want 0", fetch_err); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL basic_dvld_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (got_q[i].dcnt !== exp_q[i].dcnt || got_q[i].data !== exp_q[i].data || got_q[i].cyc != exp_q[i].cyc) begin
        n_err++; $display("FAIL basic_word%0d: got cnt=%0d data=%h cyc=%0d want cnt=%0d data=%h cyc=%0d", i,
          got_q[i].dcnt, got_q[i].data, got_q[i].cyc, exp_q[i].dcnt, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

  // Misaligned base; clr_err held high also shows set beating clear.
  task automatic test_misalign();
    bit ok;
    clear_obs();
    ll_addr = 32'h1000_0044;
    ll_req  = 1'b1;
    clr_err = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ll_ack) ok = 1'b1;
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mis_ack: ll_ack=0 after 20 cycles, want 1"); end
    tick();
    ll_req = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (fetch_err !== 1'b1) begin n_err++; $display("FAIL mis_err_set: got %b want 1", fetch_err); end
    tick();
    @(negedge clk);
    n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL mis_err_clr: got %b want 0", fetch_err); end
    clr_err = 1'b0;
    repeat (3) tick();
    n_cmp++; if (arv_cnt !== 0) begin n_err++; $display("FAIL mis_arvalid: got %0d cycles want 0", arv_cnt); end
    n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL mis_dvld: got %0d want 0", got_q.size()); end
  endtask

  task automatic test_halt();
    bit ok;
    clear_obs();
    fill_words(NW, 1'b0);
    halt    = 1'b1;
    ll_addr = 32'h2000_0100;
    ll_req  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ll_ack) ok = 1'b1;
    end
    n_cmp++; if (!ok) begin n_err++; $display("FAIL halt_ack: ll_ack=0 after 20 cycles, want 1"); end
    tick();
    ll_req  = 1'b0;
    arv_cnt = 0;
    repeat (10) tick();
    n_cmp++; if (arv_cnt !== 0) begin n_err++; $display("FAIL halt_hold: arvalid high %0d cycles want 0", arv_cnt); end
    halt = 1'b0;
    @(negedge clk);
    n_cmp++; if (arvalid !== 1'b1) begin n_err++; $display("FAIL halt_release: got %b want 1", arvalid); end
    tick();
    halt = 1'b1;
    @(negedge clk);
    n_cmp++; if (arvalid !== 1'b1) begin n_err++; $display("FAIL halt_sticky_arvalid: got %b want 1", arvalid); end
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    halt    = 1'b0;
    drive_beats(NW, 1'b0, 1'b1);
    repeat (3) tick();
    n_cmp++; if (got_q.size() != NW) begin n_err++; $display("FAIL halt_dvld_count: got %0d want %0d", got_q.size(), NW); end
  endtask

  task automatic test_slverr();
    clear_obs();
    fill_words(NW, 1'b0);
    resp_a[2] = 2'b10;
    do_req_ar(32'h3000_0020, 1'b0, 1'b1);
    drive_beats(NW, 1'b1, 1'b1);
    repeat (3) tick();
    n_cmp++; if (fetch_err !== 1'b1) begin n_err++; $display("FAIL slv_err: got %b want 1", fetch_err); end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL slv_dvld_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (got_q[i].dcnt !== exp_q[i].dcnt || got_q[i].data !== exp_q[i].data || got_q[i].cyc != exp_q[i].cyc) begin
        n_err++; $display("FAIL slv_word%0d: got cnt=%0d data=%h cyc=%0d want cnt=%0d data=%h cyc=%0d", i,
          got_q[i].dcnt, got_q[i].data, got_q[i].cyc, exp_q[i].dcnt, exp_q[i].data, exp_q[i].cyc);
      end
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL slv_clr: got %b want 0", fetch_err); end
    tick();
  endtask

  task automatic test_rst_mid();
    clear_obs();
    fill_words(NW, 1'b0);
    do_req_ar(32'h4000_0000, 1'b0, 1'b0);
    drive_beats(4, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if (ll_dvld !== 1'b0 || ll_ack !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0 ||
        fetch_err !== 1'b0 || ll_dcnt !== 3'd0 || ll_rdata !== 32'd0 || araddr !== 32'd0) begin
      n_err++; $display("FAIL rstmid_outputs: dvld=%b ack=%b arv=%b rrdy=%b err=%b dcnt=%0d rdata=%h araddr=%h want all 0",
        ll_dvld, ll_ack, arvalid, rready, fetch_err, ll_dcnt, ll_rdata, araddr);
    end
    tick();
    rst = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rstmid_dvld_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (got_q[i].dcnt !== exp_q[i].dcnt || got_q[i].data !== exp_q[i].data || got_q[i].cyc != exp_q[i].cyc) begin
        n_err++; $display("FAIL rstmid_word%0d: got cnt=%0d data=%h cyc=%0d want cnt=%0d data=%h cyc=%0d", i,
          got_q[i].dcnt, got_q[i].data, got_q[i].cyc, exp_q[i].dcnt, exp_q[i].data, exp_q[i].cyc);
      end
    end
    clear_obs();
    fill_words(NW, 1'b0);
    do_req_ar(32'h4000_0080, 1'b0, 1'b1);
    drive_beats(NW, 1'b1, 1'b1);
    repeat (3) tick();
    n_cmp++; if (got_q.size() != NW || fetch_err !== 1'b0)
      begin n_err++; $display("FAIL rstmid_after: dvld=%0d err=%b want %0d/0", got_q.size(), fetch_err, NW); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    fill_words(NW, 1'b0);
    do_req_ar(32'h5000_0000, 1'b1, 1'b1);
    drive_beats(NW, 1'b1, 1'b1);
    fill_words(NW, 1'b0);
    do_req_ar(32'h5000_0040, 1'b0, 1'b1);
    drive_beats(NW, 1'b1, 1'b1);
    repeat (3) tick();
    n_cmp++; if (ack_cnt !== 2) begin n_err++; $display("FAIL b2b_acks: got %0d want 2", ack_cnt); end
    n_cmp++; if (arv_in_r !== 0) begin n_err++; $display("FAIL b2b_arvalid_in_r: got %0d want 0", arv_in_r); end
    n_cmp++;
    if (got_q.size() != exp_q.size() || got_q.size() != 2 * NW) begin
      n_err++; $display("FAIL b2b_dvld_count: got %0d want %0d", got_q.size(), 2 * NW);
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (got_q[i].dcnt !== exp_q[i].dcnt || got_q[i].data !== exp_q[i].data || got_q[i].cyc != exp_q[i].cyc) begin
        n_err++; $display("FAIL b2b_word%0d: got cnt=%0d data=%h cyc=%0d want cnt=%0d data=%h cyc=%0d", i,
          got_q[i].dcnt, got_q[i].data, got_q[i].cyc, exp_q[i].dcnt, exp_q[i].data, exp_q[i].cyc);
      end
    end
  endtask

  // Random bursts: bad responses, short and overlong bursts, random handshakes.
  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int  nb;
      bit  exp_err;
      clear_obs();
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 8)) : int'(NW);
      fill_words(nb, 1'b1);
      exp_err = (nb != int'(NW));
      for (int b = 0; b < nb; b++) if (resp_a[b] != RESP_OKAY) exp_err = 1'b1;
      bf = 1'($urandom_range(0, 1));
      cf = 1'($urandom_range(0, 1));
      do_req_ar({$urandom_range(0, 32'h07ff_ffff), 5'd0}, 1'b0, 1'b1);
      drive_beats(nb, 1'b1, 1'b1);
      repeat (3) tick();
      n_cmp++; if (fetch_err !== exp_err)
        begin n_err++; $display("FAIL rnd%0d_err: got %b want %b (beats=%0d)", t, fetch_err, exp_err, nb); end
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL rnd%0d_dvld_count: got %0d want %0d", t, got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        n_cmp++;
        if (got_q[i].dcnt !== exp_q[i].dcnt || got_q[i].data !== exp_q[i].data || got_q[i].cyc != exp_q[i].cyc) begin
          n_err++; $display("FAIL rnd%0d_word%0d: got cnt=%0d data=%h cyc=%0d want cnt=%0d data=%h cyc=%0d", t, i,
            got_q[i].dcnt, got_q[i].data, got_q[i].cyc, exp_q[i].dcnt, exp_q[i].data, exp_q[i].cyc);
        end
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; ll_req = 1'b0; ll_addr = 32'd0; halt = 1'b0; bf = 1'b0; cf = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rdata_i = 32'd0; rresp = 2'b00; rlast = 1'b0;
    rid = '0; clr_err = 1'b0;
    test_reset();
    test_basic();
    test_misalign();
    test_halt();
    test_slverr();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
